// File: rtl/pipelined_mux_tree_pkg.sv
// Shared sizing helpers for the pipelined mux tree and its stages.
package pipelined_mux_tree_pkg;

  // Number of bits needed to encode the value v (never less than 1).
  function automatic int log2(input int v);
    int n;
    n = 1;
    for (int i = 1; i < 31; i++) begin
      if ((v >> i) != 0) n = i + 1;
    end
    return n;
  endfunction

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  function automatic int sel_out_w(input int sel_in_w, input int levels);
    return (sel_in_w > levels) ? sel_in_w - levels : 1;
  endfunction

endpackage

// File: rtl/mux_tree_stage.sv
// One pipeline slice of the mux tree: LEVELS 2:1 levels, then a register for
// the surviving nodes, the unconsumed select bits and the valid tag.
module mux_tree_stage
  import pipelined_mux_tree_pkg::*;
#(
  parameter int N_IN     = 4,
  parameter int DATA_W   = 1,
  parameter int LEVELS   = 1,
  parameter int SEL_IN_W = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  ena,
  input  logic [N_IN*DATA_W-1:0]                i_data,
  input  logic [SEL_IN_W-1:0]                   i_sel,
  input  logic                                  i_valid,
  output logic [(N_IN>>LEVELS)*DATA_W-1:0]      o_data,
  output logic [sel_out_w(SEL_IN_W,LEVELS)-1:0] o_sel,
  output logic                                  o_valid
);

  localparam int N_OUT     = N_IN >> LEVELS;
  localparam int SEL_OUT_W = sel_out_w(SEL_IN_W, LEVELS);

  logic [DATA_W-1:0]       w_node [N_IN];
  logic [N_OUT*DATA_W-1:0] w_dout;
  logic [SEL_OUT_W-1:0]    w_sout;

  logic [N_OUT*DATA_W-1:0] r_data_p;
  logic [SEL_OUT_W-1:0]    r_sel_p;
  logic                    r_vld_p;

  // Level l folds node pairs (2j, 2j+1) into node j, LSB select bit first.
  always_comb begin
    for (int j = 0; j < N_IN; j++) begin
      w_node[j] = i_data[j*DATA_W +: DATA_W];
    end
    for (int l = 0; l < LEVELS; l++) begin
      for (int j = 0; j < (N_IN >> (l + 1)); j++) begin
        w_node[j] = i_sel[l] ? w_node[2*j+1] : w_node[2*j];
      end
    end
    w_dout = '0;
    for (int j = 0; j < N_OUT; j++) begin
      w_dout[j*DATA_W +: DATA_W] = w_node[j];
    end
  end

  if (SEL_IN_W > LEVELS) begin : g_sel_pass
    assign w_sout = i_sel[SEL_IN_W-1:LEVELS];
  end else begin : g_sel_done
    assign w_sout = '0;
  end

  // ---- stage register boundary ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_p <= '0;
      r_sel_p  <= '0;
      r_vld_p  <= 1'b0;
    end else if (ena) begin
      r_data_p <= w_dout;
      r_sel_p  <= w_sout;
      r_vld_p  <= i_valid;
    end
  end

  assign o_data  = r_data_p;
  assign o_sel   = r_sel_p;
  assign o_valid = r_vld_p;

endmodule

// File: rtl/pipelined_mux_tree.sv
// Pipelined WIDTH:1 lane selector: zero-padded binary tree, registered every
// LEVELS_PER_STAGE levels, with valid tagging and a global stall enable.
module pipelined_mux_tree
  import pipelined_mux_tree_pkg::*;
#(
  parameter int WIDTH            = 64,
  parameter int DATA_W           = 1,
  parameter int LEVELS_PER_STAGE = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ena,
  input  logic [WIDTH*DATA_W-1:0]   data,
  input  logic [log2(WIDTH-1)-1:0]  sel,
  input  logic                      in_valid,
  output logic [DATA_W-1:0]         out,
  output logic                      out_valid
);

  localparam int LOG_WIDTH = log2(WIDTH - 1);
  localparam int LATENCY   = ceil_div(LOG_WIDTH, LEVELS_PER_STAGE);
  localparam int N_PAD     = 1 << LOG_WIDTH;

  // Lanes beyond WIDTH read as zero, so out-of-range selects yield 0.
  logic [N_PAD*DATA_W-1:0] w_data_pad;
  assign w_data_pad = (N_PAD*DATA_W)'(data);

  for (genvar s = 0; s < LATENCY; s++) begin : g_stage
    localparam int LVL_BASE = s * LEVELS_PER_STAGE;
    localparam int LVLS     = ((LOG_WIDTH - LVL_BASE) < LEVELS_PER_STAGE) ?
                              (LOG_WIDTH - LVL_BASE) : LEVELS_PER_STAGE;
    localparam int NI       = N_PAD >> LVL_BASE;
    localparam int SI       = LOG_WIDTH - LVL_BASE;
    localparam int SO       = sel_out_w(SI, LVLS);

    logic [NI*DATA_W-1:0]          w_din;
    logic [SI-1:0]                 w_sin;
    logic                          w_vin;
    logic [(NI>>LVLS)*DATA_W-1:0]  w_dout;
    logic [SO-1:0]                 w_sout;
    logic                          w_vout;

    if (s == 0) begin : g_first
      assign w_din = w_data_pad;
      assign w_sin = sel;
      assign w_vin = in_valid;
    end else begin : g_chain
      assign w_din = g_stage[s-1].w_dout;
      assign w_sin = g_stage[s-1].w_sout;
      assign w_vin = g_stage[s-1].w_vout;
    end

    mux_tree_stage #(
      .N_IN     (NI),
      .DATA_W   (DATA_W),
      .LEVELS   (LVLS),
      .SEL_IN_W (SI)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .ena     (ena),
      .i_data  (w_din),
      .i_sel   (w_sin),
      .i_valid (w_vin),
      .o_data  (w_dout),
      .o_sel   (w_sout),
      .o_valid (w_vout)
    );
  end

  // The last stage consumes every select bit; its residual sel is a constant.
  logic w_unused_sel;
  assign w_unused_sel = ^g_stage[LATENCY-1].w_sout;

  assign out       = g_stage[LATENCY-1].w_dout;
  assign out_valid = g_stage[LATENCY-1].w_vout;

endmodule
